// File: rtl/ecc_pkg.sv
// ecc_pkg
//   Shared definitions for the SECDED encoder/decoder pair.
//   Codeword layout (39 bits):
//     bit 0       overall parity (even parity over all 39 bits)
//     bits 1..38  Hamming positions; check bits sit at 1,2,4,8,16,32
//                 and data[31:0] fills the remaining positions in
//                 ascending order.
//   Contents: widths, syndrome/codeword/data types, error class enum,
//   data-to-position map, extract_data() and encode().
package ecc_pkg;

  localparam int DATA_WIDTH        = 32;
  localparam int MEMORY_DATA_WIDTH = 39;
  localparam int ADDR_WIDTH        = 32;
  localparam int PARITY_BITS       = 6;
  localparam int CNT_WIDTH         = 16;

  typedef logic [PARITY_BITS-1:0]       syndrome_t;
  typedef logic [MEMORY_DATA_WIDTH-1:0] codeword_t;
  typedef logic [DATA_WIDTH-1:0]        data_t;

  typedef enum logic [1:0] {ERR_NONE, ERR_SEC, ERR_PAR, ERR_DED} err_class_e;

  // Highest Hamming position; a syndrome above this cannot be a single error.
  localparam syndrome_t SYN_MAX = syndrome_t'(MEMORY_DATA_WIDTH - 1);

  localparam syndrome_t CHECK_POS [PARITY_BITS] = '{
    6'd1, 6'd2, 6'd4, 6'd8, 6'd16, 6'd32
  };

  localparam syndrome_t DATA_POS [DATA_WIDTH] = '{
    6'd3,  6'd5,  6'd6,  6'd7,  6'd9,  6'd10, 6'd11, 6'd12,
    6'd13, 6'd14, 6'd15, 6'd17, 6'd18, 6'd19, 6'd20, 6'd21,
    6'd22, 6'd23, 6'd24, 6'd25, 6'd26, 6'd27, 6'd28, 6'd29,
    6'd30, 6'd31, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd38
  };

  function automatic data_t extract_data(input codeword_t cw);
    data_t d;
    d = '0;
    for (int i = 0; i < DATA_WIDTH; i++) d[i] = cw[DATA_POS[i]];
    return d;
  endfunction

  function automatic codeword_t encode(input data_t d);
    codeword_t cw;
    logic      b;
    cw = '0;
    for (int i = 0; i < DATA_WIDTH; i++) cw[DATA_POS[i]] = d[i];
    for (int k = 0; k < PARITY_BITS; k++) begin
      b = 1'b0;
      for (int p = 1; p < MEMORY_DATA_WIDTH; p++) begin
        if (p[k] && (p != int'(CHECK_POS[k]))) b = b ^ cw[p];
      end
      cw[CHECK_POS[k]] = b;
    end
    cw[0] = ^cw[MEMORY_DATA_WIDTH-1:1];
    return cw;
  endfunction

endpackage

// File: rtl/ecc_decoding_if.sv
// ecc_decoding_if
//   Bundles the decoder's read-in stream, read-out stream, control word
//   and status outputs. slave = decoder side, master = memory/AXI side.
//   ECC_en           control ([0] correct enable, [1] clear status)
//   rd_valid_i/rd_ready_o/rd_addr_i/encoded_data_i   input stream
//   rd_valid_o/rd_ready_i/rd_addr_o/data_out         output stream
//   sec_err_o/ded_err_o                              per-beat flags
//   sec_cnt_o/ded_cnt_o/err_addr_o/err_irq_o         status
interface ecc_decoding_if;
  import ecc_pkg::*;

  logic [DATA_WIDTH-1:0]        ECC_en;
  logic                         rd_valid_i;
  logic                         rd_ready_o;
  logic [ADDR_WIDTH-1:0]        rd_addr_i;
  logic [MEMORY_DATA_WIDTH-1:0] encoded_data_i;
  logic                         rd_valid_o;
  logic                         rd_ready_i;
  logic [ADDR_WIDTH-1:0]        rd_addr_o;
  logic [DATA_WIDTH-1:0]        data_out;
  logic                         sec_err_o;
  logic                         ded_err_o;
  logic [CNT_WIDTH-1:0]         sec_cnt_o;
  logic [CNT_WIDTH-1:0]         ded_cnt_o;
  logic [ADDR_WIDTH-1:0]        err_addr_o;
  logic                         err_irq_o;

  modport slave (
    input  ECC_en, rd_valid_i, rd_addr_i, encoded_data_i, rd_ready_i,
    output rd_ready_o, rd_valid_o, rd_addr_o, data_out, sec_err_o, ded_err_o,
           sec_cnt_o, ded_cnt_o, err_addr_o, err_irq_o
  );

  modport master (
    output ECC_en, rd_valid_i, rd_addr_i, encoded_data_i, rd_ready_i,
    input  rd_ready_o, rd_valid_o, rd_addr_o, data_out, sec_err_o, ded_err_o,
           sec_cnt_o, ded_cnt_o, err_addr_o, err_irq_o
  );

endinterface

// File: rtl/ecc_syndrome_calc.sv
// ecc_syndrome_calc
//   Combinational syndrome and overall-parity generator.
//   cw_i   39-bit codeword
//   syn_o  Hamming syndrome: bit k = XOR of positions whose index has bit k set
//   par_o  XOR of all 39 bits (0 for a valid codeword)
module ecc_syndrome_calc
  import ecc_pkg::*;
(
  input  codeword_t cw_i,
  output syndrome_t syn_o,
  output logic      par_o
);

  always_comb begin
    syn_o = '0;
    for (int p = 1; p < MEMORY_DATA_WIDTH; p++) begin
      for (int k = 0; k < PARITY_BITS; k++) begin
        if (p[k]) syn_o[k] = syn_o[k] ^ cw_i[p];
      end
    end
  end

  assign par_o = ^cw_i;

endmodule

// File: rtl/ecc_decoding.sv
// ecc_decoding
//   SECDED read-path decoder: 2-stage valid/ready pipeline.
//   S1 registers address, syndrome, overall parity and raw codeword.
//   S2 classifies, corrects, extracts data and drives the output beat.
//   Ports:
//     ecc_dec_clk     clock
//     ecc_dec_rst     asynchronous active-high reset
//     ecc_dec_sw_rst  synchronous soft reset (same clearing effect)
//     bus             ecc_decoding_if.slave (streams, control, status)
module ecc_decoding
  import ecc_pkg::*;
(
  input logic           ecc_dec_clk,
  input logic           ecc_dec_rst,
  input logic           ecc_dec_sw_rst,
  ecc_decoding_if.slave bus
);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  // Only the two low control bits are defined.
  logic unused_ecc_en;
  assign unused_ecc_en = ^bus.ECC_en[DATA_WIDTH-1:2];

  logic                  vld_p1_q;
  logic [ADDR_WIDTH-1:0] addr_p1_q;
  syndrome_t             syn_p1_q;
  logic                  par_p1_q;
  codeword_t             cw_p1_q;

  logic                  vld_p2_q;
  logic [ADDR_WIDTH-1:0] addr_p2_q;
  data_t                 data_p2_q;
  logic                  sec_p2_q;
  logic                  ded_p2_q;

  logic [CNT_WIDTH-1:0]  sec_cnt_q, sec_cnt_d;
  logic [CNT_WIDTH-1:0]  ded_cnt_q, ded_cnt_d;
  logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
  logic                  irq_q, irq_d;

  syndrome_t  syn_in;
  logic       par_in;
  logic       s2_adv, rd_ready, in_acc, s2_load, out_hs;
  err_class_e cls;
  codeword_t  cw_fix;

  ecc_syndrome_calc u_syn (
    .cw_i  (bus.encoded_data_i),
    .syn_o (syn_in),
    .par_o (par_in)
  );

  // S2 can take a new beat when empty or when its beat leaves this cycle.
  assign s2_adv   = !vld_p2_q || bus.rd_ready_i;
  assign rd_ready = !vld_p1_q || s2_adv;
  assign in_acc   = bus.rd_valid_i && rd_ready;
  assign s2_load  = vld_p1_q && s2_adv;
  assign out_hs   = vld_p2_q && bus.rd_ready_i;

  // ---- S1: capture codeword, syndrome and parity ----
  always_ff @(posedge ecc_dec_clk or posedge ecc_dec_rst) begin
    if (ecc_dec_rst)         vld_p1_q <= 1'b0;
    else if (ecc_dec_sw_rst) vld_p1_q <= 1'b0;
    else if (rd_ready)       vld_p1_q <= bus.rd_valid_i;
  end

  always_ff @(posedge ecc_dec_clk) begin
    if (in_acc) begin
      addr_p1_q <= bus.rd_addr_i;
      syn_p1_q  <= syn_in;
      par_p1_q  <= par_in;
      cw_p1_q   <= bus.encoded_data_i;
    end
  end

  // ---- S1 -> S2: classify and correct ----
  always_comb begin
    cls    = ERR_NONE;
    cw_fix = cw_p1_q;
    if (syn_p1_q == '0) begin
      // Zero syndrome with odd parity means only bit 0 flipped.
      cls = par_p1_q ? ERR_PAR : ERR_NONE;
    end else if (!par_p1_q) begin
      cls = ERR_DED;
    end else if (syn_p1_q <= SYN_MAX) begin
      cls    = ERR_SEC;
      cw_fix = cw_p1_q ^ (codeword_t'(1) << syn_p1_q);
    end else begin
      cls = ERR_DED;
    end
    if (!bus.ECC_en[0]) begin
      cls    = ERR_NONE;
      cw_fix = cw_p1_q;
    end
  end

  // ---- S2: output beat, held while downstream stalls ----
  always_ff @(posedge ecc_dec_clk or posedge ecc_dec_rst) begin
    if (ecc_dec_rst) begin
      vld_p2_q  <= 1'b0;
      addr_p2_q <= '0;
      data_p2_q <= '0;
      sec_p2_q  <= 1'b0;
      ded_p2_q  <= 1'b0;
    end else if (ecc_dec_sw_rst) begin
      vld_p2_q  <= 1'b0;
      addr_p2_q <= '0;
      data_p2_q <= '0;
      sec_p2_q  <= 1'b0;
      ded_p2_q  <= 1'b0;
    end else begin
      if (s2_adv) vld_p2_q <= vld_p1_q;
      if (s2_load) begin
        addr_p2_q <= addr_p1_q;
        data_p2_q <= extract_data(cw_fix);
        sec_p2_q  <= (cls == ERR_SEC) || (cls == ERR_PAR);
        ded_p2_q  <= (cls == ERR_DED);
      end
    end
  end

  // Status: a clear request overrides a simultaneous error handshake.
  always_comb begin
    sec_cnt_d  = sec_cnt_q;
    ded_cnt_d  = ded_cnt_q;
    err_addr_d = err_addr_q;
    irq_d      = irq_q;
    if (bus.ECC_en[1]) begin
      sec_cnt_d  = '0;
      ded_cnt_d  = '0;
      err_addr_d = '0;
      irq_d      = 1'b0;
    end else if (out_hs) begin
      if (sec_p2_q) sec_cnt_d = sat_inc(sec_cnt_q);
      if (ded_p2_q) ded_cnt_d = sat_inc(ded_cnt_q);
      if ((sec_p2_q || ded_p2_q) && !irq_q) begin
        err_addr_d = addr_p2_q;
        irq_d      = 1'b1;
      end
    end
  end

  always_ff @(posedge ecc_dec_clk or posedge ecc_dec_rst) begin
    if (ecc_dec_rst) begin
      sec_cnt_q  <= '0;
      ded_cnt_q  <= '0;
      err_addr_q <= '0;
      irq_q      <= 1'b0;
    end else if (ecc_dec_sw_rst) begin
      sec_cnt_q  <= '0;
      ded_cnt_q  <= '0;
      err_addr_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      sec_cnt_q  <= sec_cnt_d;
      ded_cnt_q  <= ded_cnt_d;
      err_addr_q <= err_addr_d;
      irq_q      <= irq_d;
    end
  end

  assign bus.rd_ready_o = rd_ready;
  assign bus.rd_valid_o = vld_p2_q;
  assign bus.rd_addr_o  = addr_p2_q;
  assign bus.data_out   = data_p2_q;
  assign bus.sec_err_o  = sec_p2_q;
  assign bus.ded_err_o  = ded_p2_q;
  assign bus.sec_cnt_o  = sec_cnt_q;
  assign bus.ded_cnt_o  = ded_cnt_q;
  assign bus.err_addr_o = err_addr_q;
  assign bus.err_irq_o  = irq_q;

endmodule
